alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Multi-alarm controller for the clock project; next generation of the single-alarm buzzer logic.
- Compares N programmable BCD alarm times against current time on each minute strobe.
- Provides ring/snooze/stop state machine, automatic ring timeout, and a beeping square-wave drive for the buzzer.
- Sits between the timekeeping counters, the alarm-setting registers, the debounced buttons and the buzzer pin.

Parameters:
- N_ALARMS, 4, number of independent alarms (1..8)
- DIGITS, 4, BCD digits per time value (HH:MM = 4)
- SNOOZE_MIN, 5, snooze length in minute ticks (1..15)
- RING_MAX_MIN, 3, ring minutes before auto-off (1..15)
- TONE_DIV, 25000, clk cycles per tone half-period (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- min_tick  in  1  one-clk pulse at each minute rollover, synchronous to clk
- sec_tick  in  1  one-clk pulse each second, synchronous to clk
- time_bcd  in  4*DIGITS  current time, digit 0 in LSBs
- alarm_bcd  in  N_ALARMS*4*DIGITS  alarm k occupies slice [k*4*DIGITS +: 4*DIGITS]
- alarm_en  in  N_ALARMS  per-alarm enable
- btn_stop  in  1  debounced one-clk pulse
- btn_snooze  in  1  debounced one-clk pulse
- son  out  1  buzzer drive
- ringing  out  1  high in RING
- snoozed  out  1  high in SNOOZE
- active_idx  out  max(1,$clog2(N_ALARMS))  index of the alarm currently owning RING/SNOOZE

Behaviour:
- Reset values: state IDLE; son=0, ringing=0, snoozed=0, active_idx=0; all counters 0.
- match[k] = alarm_en[k] & (alarm slice k == time_bcd). The comparison is combinational. Winner is the lowest set index.
- All state changes are registered. An event sampled at edge t is visible on the outputs after edge t.

State machine (IDLE, RING, SNOOZE):
- IDLE: min_tick & |match -> RING. active_idx=winner, ring_cnt=0. btn_stop and btn_snooze are ignored in IDLE.
- RING:
  - btn_stop -> IDLE.
  - Else btn_snooze -> SNOOZE with snz_cnt=SNOOZE_MIN.
  - Else on min_tick: ring_cnt+1. If it reaches RING_MAX_MIN -> IDLE (auto-off).
  - Matches of other alarms while in RING are ignored.
- SNOOZE:
  - btn_stop -> IDLE.
  - Else min_tick & |match -> RING with the new winner, ring_cnt=0. A new alarm pre-empts the snooze.
  - Else on min_tick: snz_cnt-1. On reaching 0 -> RING, same active_idx, ring_cnt=0.
  - btn_snooze is ignored in SNOOZE.
- Priority within one cycle: btn_stop > btn_snooze > min_tick events.
- If alarm_en[active_idx] is deasserted while in RING or SNOOZE -> IDLE on the next edge.
- active_idx holds its last value in IDLE.

Tone generation:
- tone_sq toggles every TONE_DIV clk cycles while ringing=1.
- On every entry to RING, the divider is cleared and tone_sq=0.
- beep toggles on each sec_tick in RING and is set to 1 on RING entry. This gives 1 s on / 1 s off.
- son = ringing & beep & tone_sq, registered. son is 0 in IDLE and SNOOZE.
- Reset asserted mid-ring: son drops immediately (asynchronous). After release the block resumes in IDLE.
- Counter widths: ring_cnt and snz_cnt are 4 bits. The tone divider is $clog2(TONE_DIV) bits and wraps to 0 after TONE_DIV-1.

Decomposition:
- Package alarm_pkg: state encoding constants (IDLE=2'd0, RING=2'd1, SNOOZE=2'd2) and the BCD digit width constant (4).
- Sub-module tone_gen (clk, rst_n, run, sec_tick -> son): holds the divider, tone_sq and beep. run is ringing, and a rising edge of run clears the divider, tone_sq and beep state.
- Comparator and priority encoder stay inline in alarm_ctrl.

Test Plan (TONE_DIV=4, SNOOZE_MIN=2, RING_MAX_MIN=3, N_ALARMS=4):
- Basic ring: alarm 2 = 07:30, enabled; time_bcd=0730; pulse min_tick -> ringing=1, active_idx=2 next edge; son toggles every 4 clk while beep=1; btn_stop -> ringing=0, son=0 next edge.
- Priority and enable: alarms 1 and 3 = 06:00, alarm 1 disabled; min_tick at 0600 -> active_idx=3. Then clear alarm_en[3] -> IDLE next edge.
- Snooze: ring, btn_snooze -> snoozed=1, son=0. Two min_ticks (no match) -> ringing=1, same active_idx. btn_stop and btn_snooze on the same cycle while ringing -> IDLE.
- Auto-off: ring with no buttons; after 3 min_ticks -> IDLE, son=0.
- Pre-empt: in SNOOZE for alarm 0, min_tick with alarm 1 matching -> RING, active_idx=1, ring_cnt restarted (auto-off after 3 more ticks).
- Reset: assert rst_n=0 during RING with son=1 -> son, ringing, snoozed drop to 0 without waiting for clk. After release, the state stays IDLE until the next matching min_tick.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the multi-alarm controller: FSM encoding and BCD digit width.
package alarm_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

endpackage

// File: rtl/tone_gen.sv
// Buzzer drive: a TONE_DIV square wave gated by a 1 s on / 1 s off beep, restarted on every ring entry.
module tone_gen #(
  parameter int TONE_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic sec_tick,
  output logic son
);

  localparam int DW = $clog2(TONE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TONE_DIV - 1);

  logic [DW-1:0] div_reg, div_next;
  logic          tone_reg, tone_next;
  logic          beep_reg, beep_next;
  logic          run_reg;
  logic          son_reg;

  always_comb begin
    div_next  = '0;
    tone_next = 1'b0;
    beep_next = 1'b0;
    if (run && !run_reg) begin
      // Fresh ring: start silent in the tone phase but with the beep gate open.
      beep_next = 1'b1;
    end else if (run) begin
      tone_next = tone_reg;
      beep_next = beep_reg ^ sec_tick;
      if (div_reg == DIV_LAST) begin
        tone_next = ~tone_reg;
      end else begin
        div_next = div_reg + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg  <= '0;
      tone_reg <= 1'b0;
      beep_reg <= 1'b0;
      run_reg  <= 1'b0;
      son_reg  <= 1'b0;
    end else begin
      div_reg  <= div_next;
      tone_reg <= tone_next;
      beep_reg <= beep_next;
      run_reg  <= run;
      son_reg  <= run & beep_next & tone_next;
    end
  end

  assign son = son_reg;

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-alarm controller: compares N BCD alarm times on each minute strobe and runs ring/snooze/stop.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int N_ALARMS     = 4,
  parameter int DIGITS       = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_MIN = 3,
  parameter int TONE_DIV     = 25000,
  localparam int TW = BCD_W * DIGITS,
  localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   min_tick,
  input  logic                   sec_tick,
  input  logic [TW-1:0]          time_bcd,
  input  logic [N_ALARMS*TW-1:0] alarm_bcd,
  input  logic [N_ALARMS-1:0]    alarm_en,
  input  logic                   btn_stop,
  input  logic                   btn_snooze,
  output logic                   son,
  output logic                   ringing,
  output logic                   snoozed,
  output logic [IW-1:0]          active_idx
);

  localparam logic [3:0] SNZ_LOAD = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_MAX = 4'(RING_MAX_MIN);

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [3:0]    ring_cnt_reg, ring_cnt_next;
  logic [3:0]    snz_cnt_reg, snz_cnt_next;

  logic [N_ALARMS-1:0] match;
  logic [IW-1:0]       winner;
  logic                any_match;
  logic                owner_en;

  generate
    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_cmp
      assign match[gi] = alarm_en[gi] && (alarm_bcd[gi*TW +: TW] == time_bcd);
    end
  endgenerate

  // Scan downwards so the lowest matching index is left in winner.
  always_comb begin
    winner = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (match[k]) winner = IW'(k);
    end
  end

  assign any_match = |match;
  assign owner_en  = alarm_en[idx_reg];

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    ring_cnt_next = ring_cnt_reg;
    snz_cnt_next  = snz_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (min_tick && any_match) begin
          state_next    = RING;
          idx_next      = winner;
          ring_cnt_next = '0;
        end
      end
      RING: begin
        if (btn_stop || !owner_en) begin
          state_next = IDLE;
        end else if (btn_snooze) begin
          state_next   = SNOOZE;
          snz_cnt_next = SNZ_LOAD;
        end else if (min_tick) begin
          ring_cnt_next = ring_cnt_reg + 4'd1;
          if (ring_cnt_reg + 4'd1 >= RING_MAX) state_next = IDLE;
        end
      end
      SNOOZE: begin
        if (btn_stop || !owner_en) begin
          state_next = IDLE;
        end else if (min_tick && any_match) begin
          state_next    = RING;
          idx_next      = winner;
          ring_cnt_next = '0;
        end else if (min_tick) begin
          snz_cnt_next = snz_cnt_reg - 4'd1;
          if (snz_cnt_reg <= 4'd1) begin
            state_next    = RING;
            ring_cnt_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      ring_cnt_reg <= '0;
      snz_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      ring_cnt_reg <= ring_cnt_next;
      snz_cnt_reg  <= snz_cnt_next;
    end
  end

  // Fed from the next state so tone registers and son update on the same edge as ringing.
  tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state_next == RING),
    .sec_tick (sec_tick),
    .son      (son)
  );

  assign ringing    = (state_reg == RING);
  assign snoozed    = (state_reg == SNOOZE);
  assign active_idx = idx_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: expected outputs queued per driven cycle, popped after the edge.
module tb_alarm_ctrl;

  localparam int NA = 4;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          min_tick, sec_tick, btn_stop, btn_snooze;
  logic [15:0]   time_bcd;
  logic [63:0]   alarm_bcd;
  logic [NA-1:0] alarm_en;
  logic          son, ringing, snoozed;
  logic [1:0]    active_idx;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .N_ALARMS(NA), .DIGITS(4), .SNOOZE_MIN(2), .RING_MAX_MIN(3), .TONE_DIV(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .min_tick(min_tick), .sec_tick(sec_tick),
    .time_bcd(time_bcd), .alarm_bcd(alarm_bcd), .alarm_en(alarm_en),
    .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .son(son), .ringing(ringing), .snoozed(snoozed), .active_idx(active_idx)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  typedef struct packed {
    logic       r;
    logic       s;
    logic [1:0] idx;
    logic       son;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  // Expected FSM view for the cycle being driven, set by the test sequence.
  logic       e_r = 1'b0, e_s = 1'b0;
  logic [1:0] e_i = 2'd0;
  // Tone model: edges since ring entry and the beep gate.
  int   age    = 0;
  logic beep_m = 1'b0;
  logic prev_r = 1'b0;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_MT   = 4'b1000;
  localparam logic [3:0] P_SEC  = 4'b0100;
  localparam logic [3:0] P_STOP = 4'b0010;
  localparam logic [3:0] P_SNZ  = 4'b0001;

  task automatic step(input string tag, input logic [3:0] p);
    exp_t  e;
    string t;
    {min_tick, sec_tick, btn_stop, btn_snooze} = p;
    if (e_r && !prev_r) begin
      age    = 0;
      beep_m = 1'b1;
    end else if (e_r) begin
      age++;
      if (p[2]) beep_m = ~beep_m;
    end
    prev_r = e_r;
    e.r   = e_r;
    e.s   = e_s;
    e.idx = e_i;
    e.son = e_r && beep_m && (((age / TD) % 2) == 1);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    {min_tick, sec_tick, btn_stop, btn_snooze} = 4'b0000;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".ringing"}, 32'(ringing), 32'(e.r));
    check({t, ".snoozed"}, 32'(snoozed), 32'(e.s));
    check({t, ".idx"}, 32'(active_idx), 32'(e.idx));
    check({t, ".son"}, 32'(son), 32'(e.son));
    $display("step %-10s ring=%0b snz=%0b idx=%0d son=%0b", t, ringing, snoozed, active_idx, son);
  endtask

  task automatic run_n(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, P_NONE);
  endtask

  initial begin
    rst_n = 1'b0;
    {min_tick, sec_tick, btn_stop, btn_snooze} = 4'b0000;
    time_bcd  = 16'h0000;
    alarm_bcd = {16'h0600, 16'h0730, 16'h0600, 16'h0000};
    alarm_en  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ringing", 32'(ringing), 32'd0);
    check("rst.snoozed", 32'(snoozed), 32'd0);
    check("rst.idx", 32'(active_idx), 32'd0);
    check("rst.son", 32'(son), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic ring on alarm 2 with tone and beep gating.
    alarm_en = 4'b0100;
    time_bcd = 16'h0730;
    e_r = 1'b1; e_i = 2'd2;
    step("b_ring", P_MT);
    run_n("b_tone", 7);
    step("b_sec0", P_SEC);
    run_n("b_quiet", 4);
    step("b_sec1", P_SEC);
    run_n("b_tone2", 2);
    e_r = 1'b0;
    step("b_stop", P_STOP);

    // Lowest enabled index wins; dropping the owner's enable ends the ring.
    alarm_en = 4'b1000;
    time_bcd = 16'h0600;
    e_r = 1'b1; e_i = 2'd3;
    step("p_ring3", P_MT);
    run_n("p_hold", 2);
    alarm_en = 4'b0000;
    e_r = 1'b0;
    step("p_endis", P_NONE);
    step("p_btnidl", P_STOP | P_SNZ);
    alarm_en = 4'b1010;
    e_r = 1'b1; e_i = 2'd1;
    step("p_ring1", P_MT);
    e_r = 1'b0;
    step("p_stop", P_STOP);
    time_bcd = 16'h0601;
    step("p_nomatch", P_MT);

    // Snooze countdown back into RING, then stop+snooze together.
    alarm_bcd = {16'h0600, 16'h0730, 16'h0900, 16'h0800};
    alarm_en  = 4'b0001;
    time_bcd  = 16'h0800;
    e_r = 1'b1; e_i = 2'd0;
    step("s_ring", P_MT);
    run_n("s_tone", 4);
    e_r = 1'b0; e_s = 1'b1;
    step("s_snz", P_SNZ);
    time_bcd = 16'h0801;
    step("s_tick1", P_MT);
    step("s_snzign", P_SNZ);
    e_r = 1'b1; e_s = 1'b0;
    step("s_tick2", P_MT);
    run_n("s_tone2", 4);
    e_r = 1'b0;
    step("s_stopsnz", P_STOP | P_SNZ);

    // Auto-off after three minute ticks in RING.
    time_bcd = 16'h0800;
    e_r = 1'b1;
    step("a_ring", P_MT);
    run_n("a_tone", 4);
    step("a_tick1", P_MT);
    run_n("a_tone", 2);
    step("a_tick2", P_MT);
    run_n("a_tone", 1);
    e_r = 1'b0;
    step("a_off", P_MT);
    run_n("a_idle", 2);

    // A new match pre-empts SNOOZE and restarts the ring count.
    alarm_en = 4'b0011;
    e_r = 1'b1; e_i = 2'd0;
    step("e_ring0", P_MT);
    e_r = 1'b0; e_s = 1'b1;
    step("e_snz", P_SNZ);
    time_bcd = 16'h0900;
    e_r = 1'b1; e_s = 1'b0; e_i = 2'd1;
    step("e_pre", P_MT);
    run_n("e_tone", 4);
    step("e_tick1", P_MT);
    step("e_tick2", P_MT);
    e_r = 1'b0;
    step("e_off", P_MT);

    // Asynchronous reset while son is high.
    alarm_en = 4'b0010;
    e_r = 1'b1; e_i = 2'd1;
    step("r_ring", P_MT);
    run_n("r_tone", 4);
    check("r_pre.son", 32'(son), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r_async.son", 32'(son), 32'd0);
    check("r_async.ringing", 32'(ringing), 32'd0);
    check("r_async.snoozed", 32'(snoozed), 32'd0);
    check("r_async.idx", 32'(active_idx), 32'd0);
    e_r = 1'b0; e_s = 1'b0; e_i = 2'd0; prev_r = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_n("r_idle", 3);
    e_r = 1'b1; e_i = 2'd1;
    step("r_ring2", P_MT);
    e_r = 1'b0;
    step("r_stop", P_STOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
